// File: rtl/game_timer.sv
// Round countdown timer driven by vsync frame ticks, with BCD-style min/sec digits
// and a blinking low-time warning.
module game_timer #(
  parameter int GAME_SECONDS   = 180,
  parameter int FRAMES_PER_SEC = 60,
  parameter int LOW_THRESH     = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [2:0] game_state,
  output logic [7:0] time_left,
  output logic       timer_go,
  output logic       sec_pulse,
  output logic [2:0] time_min,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       low_warn
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_EXPIRED = 3'd4;

  localparam logic [2:0] GS_WELCOME = 3'd0;
  localparam logic [2:0] GS_START   = 3'd1;
  localparam logic [2:0] GS_PLAY    = 3'd2;
  localparam logic [2:0] GS_PAUSE   = 3'd3;
  localparam logic [2:0] GS_FINISH  = 3'd4;

  // Load digits are elaboration-time constants; no runtime division.
  localparam logic [7:0] INIT_TIME  = 8'(GAME_SECONDS);
  localparam logic [2:0] INIT_MIN   = 3'(GAME_SECONDS / 60);
  localparam logic [2:0] INIT_TENS  = 3'((GAME_SECONDS % 60) / 10);
  localparam logic [3:0] INIT_ONES  = 4'(GAME_SECONDS % 10);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] BLINK_LAST = 8'(FRAMES_PER_SEC / 2 - 1);
  localparam logic [7:0] LOW_T      = 8'(LOW_THRESH);

  logic       vs_sync1, vs_sync2, vs_prev;
  logic       frame_tick;
  logic [2:0] state_q, state_d;
  logic [7:0] time_left_q, time_left_d;
  logic [2:0] time_min_q, time_min_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;
  logic       sec_pulse_q, sec_pulse_d;
  logic       timer_go_q;
  logic       count_en;
  logic       counted_tick;
  logic       zone_q, zone_d;

  assign frame_tick = vs_prev & ~vs_sync2;

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    time_min_d  = time_min_q;
    sec_tens_d  = sec_tens_q;
    sec_ones_d  = sec_ones_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    sec_pulse_d = 1'b0;
    count_en    = 1'b0;

    if (game_state == GS_WELCOME) begin
      state_d     = ST_IDLE;
      time_left_d = INIT_TIME;
      time_min_d  = INIT_MIN;
      sec_tens_d  = INIT_TENS;
      sec_ones_d  = INIT_ONES;
      frame_cnt_d = 8'd0;
    end else if (game_state <= GS_FINISH) begin
      case (state_q)
        ST_IDLE: begin
          if (game_state == GS_START)     state_d = ST_ARMED;
          else if (game_state == GS_PLAY) state_d = ST_RUN;
        end
        ST_ARMED: if (game_state == GS_PLAY) state_d = ST_RUN;
        ST_RUN: begin
          if (game_state == GS_PAUSE)       state_d = ST_HOLD;
          else if (game_state == GS_FINISH) state_d = ST_EXPIRED;
          else                              count_en = 1'b1;
        end
        ST_HOLD: begin
          if (game_state == GS_PLAY)        state_d = ST_RUN;
          else if (game_state == GS_FINISH) state_d = ST_EXPIRED;
        end
        ST_EXPIRED: ;
        default: state_d = ST_IDLE;
      endcase
    end

    counted_tick = count_en & frame_tick;
    if (counted_tick) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = 8'd0;
        if (time_left_q != 8'd0) begin
          time_left_d = time_left_q - 8'd1;
          sec_pulse_d = 1'b1;
          if (time_left_q == 8'd1) state_d = ST_EXPIRED;
          if (sec_ones_q == 4'd0) begin
            sec_ones_d = 4'd9;
            if (sec_tens_q == 3'd0) begin
              sec_tens_d = 3'd5;
              time_min_d = time_min_q - 3'd1;
            end else begin
              sec_tens_d = sec_tens_q - 3'd1;
            end
          end else begin
            sec_ones_d = sec_ones_q - 4'd1;
          end
        end
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end

    // Blink phase only advances on ticks counted while already inside the low zone.
    zone_q = (time_left_q != 8'd0) && (time_left_q <= LOW_T);
    zone_d = (time_left_d != 8'd0) && (time_left_d <= LOW_T);
    if (!(zone_d && (state_d == ST_RUN || state_d == ST_HOLD))) begin
      blink_d     = 1'b0;
      blink_cnt_d = 8'd0;
    end else if (counted_tick && zone_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_sync1    <= 1'b0;
      vs_sync2    <= 1'b0;
      vs_prev     <= 1'b0;
      state_q     <= ST_IDLE;
      time_left_q <= INIT_TIME;
      time_min_q  <= INIT_MIN;
      sec_tens_q  <= INIT_TENS;
      sec_ones_q  <= INIT_ONES;
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
      sec_pulse_q <= 1'b0;
      timer_go_q  <= 1'b0;
    end else begin
      vs_sync1    <= vsync;
      vs_sync2    <= vs_sync1;
      vs_prev     <= vs_sync2;
      state_q     <= state_d;
      time_left_q <= time_left_d;
      time_min_q  <= time_min_d;
      sec_tens_q  <= sec_tens_d;
      sec_ones_q  <= sec_ones_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      sec_pulse_q <= sec_pulse_d;
      timer_go_q  <= (state_q == ST_RUN);
    end
  end

  always_comb begin
    if (state_q == ST_EXPIRED)                           low_warn = 1'b1;
    else if (state_q == ST_RUN || state_q == ST_HOLD)    low_warn = blink_q;
    else                                                 low_warn = 1'b0;
  end

  assign time_left = time_left_q;
  assign time_min  = time_min_q;
  assign sec_tens  = sec_tens_q;
  assign sec_ones  = sec_ones_q;
  assign sec_pulse = sec_pulse_q;
  assign timer_go  = timer_go_q;

endmodule

// File: tb/tb_game_timer.sv
// Randomized bench for game_timer; a seconds/frames reference model is compared every clock.
module tb_game_timer;
  localparam int GS  = 70;
  localparam int FPS = 4;
  localparam int LT  = 5;

  localparam int MIdle = 0, MArmed = 1, MRun = 2, MHold = 3, MExp = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [2:0] game_state;
  logic [7:0] time_left;
  logic       timer_go, sec_pulse, low_warn;
  logic [2:0] time_min, sec_tens;
  logic [3:0] sec_ones;

  game_timer #(
    .GAME_SECONDS  (GS),
    .FRAMES_PER_SEC(FPS),
    .LOW_THRESH    (LT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .game_state(game_state),
    .time_left (time_left),
    .timer_go  (timer_go),
    .sec_pulse (sec_pulse),
    .time_min  (time_min),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .low_warn  (low_warn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference model: mode, whole seconds, frames into current second, ticks seen in low zone.
  int m_mode = MIdle, m_time = GS, m_frames = 0, m_low_ticks = 0;
  bit m_go = 0, m_pulse = 0;
  bit vs_hist [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_warn();
    if (m_mode == MExp) return 1;
    if (m_mode == MRun || m_mode == MHold) return (m_low_ticks / (FPS / 2)) % 2;
    return 0;
  endfunction

  task automatic model_edge();
    bit tick;
    m_go = (m_mode == MRun) && !reset;
    m_pulse = 0;
    if (reset) begin
      m_mode = MIdle; m_time = GS; m_frames = 0; m_low_ticks = 0;
      for (int i = 0; i < 3; i++) vs_hist[i] = 0;
      return;
    end
    // A frame tick is a falling edge seen after two synchronizer stages.
    tick = vs_hist[2] && !vs_hist[1];
    vs_hist[2] = vs_hist[1];
    vs_hist[1] = vs_hist[0];
    vs_hist[0] = vsync;
    if (game_state == 0) begin
      m_mode = MIdle; m_time = GS; m_frames = 0;
    end else if (game_state <= 4) begin
      case (m_mode)
        MIdle:  if (game_state == 1) m_mode = MArmed; else if (game_state == 2) m_mode = MRun;
        MArmed: if (game_state == 2) m_mode = MRun;
        MRun: begin
          if (game_state == 3) m_mode = MHold;
          else if (game_state == 4) m_mode = MExp;
          else if (tick) begin
            if (m_time >= 1 && m_time <= LT) m_low_ticks++;
            m_frames++;
            if (m_frames == FPS) begin
              m_frames = 0;
              if (m_time > 0) begin
                m_time--;
                m_pulse = 1;
                if (m_time == 0) m_mode = MExp;
              end
            end
          end
        end
        MHold: if (game_state == 2) m_mode = MRun; else if (game_state == 4) m_mode = MExp;
        default: ;
      endcase
    end
    if (!((m_mode == MRun || m_mode == MHold) && m_time >= 1 && m_time <= LT)) m_low_ticks = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("time_left", time_left, m_time);
    check("time_min", time_min, m_time / 60);
    check("sec_tens", sec_tens, (m_time % 60) / 10);
    check("sec_ones", sec_ones, m_time % 10);
    check("invariant", 60 * time_min + 10 * sec_tens + sec_ones, time_left);
    check("timer_go", timer_go, m_go);
    check("sec_pulse", sec_pulse, m_pulse);
    check("low_warn", low_warn, model_warn());
    if (sec_pulse) pulses++;
  endtask

  task automatic frame();
    int hi, lo;
    hi = $urandom_range(2, 4);
    lo = $urandom_range(3, 5);
    vsync = 1'b1;
    for (int i = 0; i < hi; i++) step();
    vsync = 1'b0;
    for (int i = 0; i < lo; i++) step();
  endtask

  task automatic run_to(input int target, input string tag);
    for (int i = 0; i < 400 && time_left != 8'(target); i++) frame();
    check(tag, time_left, target);
  endtask

  initial begin
    int p0, t0, r;
    reset = 1'b1; vsync = 1'b0; game_state = 3'd0;
    step(); step();
    check("rst_time", time_left, 70);
    check("rst_go", timer_go, 0);
    reset = 1'b0;
    frame(); frame();
    game_state = 3'd1;
    frame(); frame();
    check("armed_hold", time_left, 70);
    game_state = 3'd2;
    p0 = pulses;
    for (int i = 0; i < 4; i++) frame();
    check("first_sec", time_left, 69);
    check("first_min", time_min, 1);
    check("first_tens", sec_tens, 0);
    check("first_ones", sec_ones, 9);
    check("first_pulses", pulses - p0, 1);
    check("first_go", timer_go, 1);

    run_to(60, "reach60");
    for (int i = 0; i < 4; i++) frame();
    check("borrow_time", time_left, 59);
    check("borrow_digits", {time_min, sec_tens, sec_ones}, {3'd0, 3'd5, 4'd9});

    frame(); frame();
    t0 = time_left;
    game_state = 3'd3;
    for (int i = 0; i < 10; i++) frame();
    check("pause_frozen", time_left, t0);
    check("pause_go", timer_go, 0);
    game_state = 3'd2;
    frame();
    check("resume_1tick", time_left, t0);
    frame();
    check("resume_2tick", time_left, t0 - 1);

    run_to(3, "reach3");
    reset = 1'b1;
    step();
    check("midrun_rst_time", time_left, 70);
    check("midrun_rst_go", timer_go, 0);
    check("midrun_rst_warn", low_warn, 0);
    reset = 1'b0;
    game_state = 3'd0; step();
    game_state = 3'd1; step();
    game_state = 3'd2;
    run_to(0, "reach0");
    step(); step();
    check("exp_go", timer_go, 0);
    check("exp_warn", low_warn, 1);
    p0 = pulses;
    frame(); frame(); frame();
    check("exp_no_pulse", pulses - p0, 0);
    check("exp_time", time_left, 0);
    game_state = 3'd4; frame();
    game_state = 3'd0; step();
    check("reload", time_left, 70);

    // Frame-aligned random state changes, including illegal codes and occasional reset.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      game_state = 3'd2;
      else if (r < 14) game_state = 3'd3;
      else if (r < 15) game_state = 3'd0;
      else if (r < 16) game_state = 3'd1;
      else if (r < 17) game_state = 3'd4;
      else             game_state = 3'(5 + r % 3);
      reset = ($urandom_range(0, 99) == 0);
      frame();
    end
    reset = 1'b0;
    game_state = 3'd0; step();
    // Cycle-level noise so state changes collide with frame ticks.
    for (int n = 0; n < 2500; n++) begin
      vsync = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 24) == 0) begin
        r = $urandom_range(0, 9);
        game_state = (r < 6) ? 3'd2 : 3'(r - 5);
      end
      reset = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
